shifter_arbiter: RTL and testbench
==================================

Name: shifter_arbiter

Overview:
- Shares one registered barrel-shift datapath between two requesters: requester 0 is the ALU shift path and requester 1 is the multdiv/aux unit.
- Supports SLL and SRA. SRA reuses the left-shift core: reverse bits, shift left, reverse again, then sign-fill the vacated high bits.
- Round-robin arbitration with a single-cycle request/grant handshake and a 1-cycle result latency.
- Sits between the ALU-level shift opcodes and the shifter core.

Parameters:
- WIDTH, 32, operand and result width in bits.
- SHAMT_W, 5, shift-amount width; must equal log2(WIDTH).

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req0  input  1  requester 0 has a valid shift request this cycle.
- op0  input  1  requester 0 operation: 0 = SLL, 1 = SRA.
- data_operandA0  input  WIDTH  requester 0 operand.
- ctrl_shiftamt0  input  SHAMT_W  requester 0 shift amount.
- gnt0  output  1  combinational grant to requester 0.
- req1, op1, data_operandA1, ctrl_shiftamt1, gnt1: same as above, for requester 1.
- data_result  output  WIDTH  registered shift result.
- done0  output  1  data_result belongs to requester 0; 1-cycle pulse.
- done1  output  1  data_result belongs to requester 1; 1-cycle pulse.

Behaviour:
- Reset: data_result=0, done0=0, done1=0, priority pointer=0 (requester 0 favoured). gnt0/gnt1 are 0 while reset is high. Reset asserted mid-operation discards the in-flight result: no done pulse in the cycle after reset.
- Arbitration (combinational, from req0, req1 and the pointer):
  - Only one request high: that requester is granted.
  - Both requests high: the requester selected by the pointer is granted.
  - No requests: no grant, pointer unchanged.
  - gnt0 and gnt1 are never high together.
- Pointer update on each accepted transfer (req & gnt): pointer moves to the other requester, so back-to-back contention alternates 0,1,0,1.
- Handshake:
  - A transfer is accepted in cycle N when reqX && gntX.
  - The requester holds its request, operand and op stable until granted. An ungranted request is not latched; the requester simply retries.
  - One transfer is accepted per cycle, giving full throughput.
- Latency: for a transfer accepted in cycle N, data_result and doneX are valid in cycle N+1.
  - doneX is high for exactly one cycle per accepted transfer.
  - data_result holds its last value when no done is asserted.
- Arithmetic:
  - SLL: result = A << shamt, zero fill.
  - SRA: result = A >>> shamt. The top shamt bits equal A[WIDTH-1].
  - shamt = 0 returns A unchanged for both ops.
  - shamt = WIDTH-1: SLL gives A[0] in the MSB with all other bits 0. SRA gives all bits equal to the sign bit.
  - Shift amounts are unsigned. There is no overflow flag.
- Datapath structure:
  - Operand, shamt, op and owner id are selected by the grant and computed combinationally by the shared core.
  - The result is registered at the output.
  - Exactly one left-shift core instance exists in the block.

Test Plan:
- Reset then idle: data_result=0, done0=done1=0, gnt0=gnt1=0 for 5 cycles.
- req0 only, SLL, A=0x00000001, shamt=31 -> gnt0=1 that cycle; next cycle data_result=0x80000000, done0=1, done1=0.
- req1 only, SRA, A=0x80000000, shamt=4 -> next cycle data_result=0xF8000000, done1=1. Also check SRA A=0x40000000, shamt=30 -> 0x00000001.
- Both requesting continuously for 4 cycles: grants 0,1,0,1; the done pulses follow one cycle later in the same order; results match the per-requester operands (SLL 0x1 shamt=1 -> 0x2 for req0; SRA 0xFFFFFFF0 shamt=4 -> 0xFFFFFFFF for req1).
- shamt=0 for both ops with A=0xDEADBEEF -> result 0xDEADBEEF.
- Accept req0 in cycle N, assert reset in cycle N+1 -> no done0 is observed after reset, data_result=0, and the pointer favours requester 0 on the next contention.

Source files
------------

// File: rtl/shifter_arbiter.sv
// Two-requester round-robin front end for a single registered shifter.
// Requester 0 is the ALU shift path, requester 1 the multdiv/aux unit.
// SLL and SRA share one left-shift core; SRA reverses the operand bits,
// shifts left, reverses back, then sign-fills the vacated high bits.
module shifter_arbiter #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               req0,
  input  logic               op0,
  input  logic [WIDTH-1:0]   data_operandA0,
  input  logic [SHAMT_W-1:0] ctrl_shiftamt0,
  output logic               gnt0,
  input  logic               req1,
  input  logic               op1,
  input  logic [WIDTH-1:0]   data_operandA1,
  input  logic [SHAMT_W-1:0] ctrl_shiftamt1,
  output logic               gnt1,
  output logic [WIDTH-1:0]   data_result,
  output logic               done0,
  output logic               done1
);

  // r_ptr = 0 favours requester 0 under contention, 1 favours requester 1
  logic               r_ptr;
  logic [WIDTH-1:0]   r_result;
  logic               r_done0;
  logic               r_done1;

  logic               w_gnt0;
  logic               w_gnt1;
  logic               w_op;
  logic [WIDTH-1:0]   w_a;
  logic [SHAMT_W-1:0] w_shamt;
  logic [WIDTH-1:0]   w_core_in;
  logic [WIDTH-1:0]   w_core_out;
  logic [WIDTH-1:0]   w_unrev;
  logic [WIDTH-1:0]   w_fill;
  logic [WIDTH-1:0]   w_shift_res;

  // Grant: single request wins outright, contention resolved by pointer
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (!reset) begin
      if (req0 && req1) begin
        w_gnt0 = ~r_ptr;
        w_gnt1 = r_ptr;
      end else begin
        w_gnt0 = req0;
        w_gnt1 = req1;
      end
    end
  end

  assign gnt0 = w_gnt0;
  assign gnt1 = w_gnt1;

  // Operand mux steered by the grant, then the single shared shift core
  always_comb begin
    w_op      = w_gnt1 ? op1            : op0;
    w_a       = w_gnt1 ? data_operandA1 : data_operandA0;
    w_shamt   = w_gnt1 ? ctrl_shiftamt1 : ctrl_shiftamt0;
    w_core_in = w_op ? {<<{w_a}} : w_a;
    w_core_out = w_core_in << w_shamt;
    w_unrev   = {<<{w_core_out}};
    // Top w_shamt bits set: these are the positions vacated by a right shift
    w_fill    = ~({WIDTH{1'b1}} >> w_shamt);
    if (w_op)
      w_shift_res = w_unrev | (w_a[WIDTH-1] ? w_fill : '0);
    else
      w_shift_res = w_core_out;
  end

  // Register result and owner pulse; rotate pointer on each accepted transfer
  always_ff @(posedge clock) begin
    if (reset) begin
      r_result <= '0;
      r_done0  <= 1'b0;
      r_done1  <= 1'b0;
      r_ptr    <= 1'b0;
    end else begin
      r_done0 <= w_gnt0;
      r_done1 <= w_gnt1;
      if (w_gnt0 || w_gnt1) begin
        r_result <= w_shift_res;
        r_ptr    <= w_gnt0;
      end
    end
  end

  assign data_result = r_result;
  assign done0       = r_done0;
  assign done1       = r_done1;

endmodule

// File: tb/tb_shifter_arbiter.sv
// Self-checking bench for shifter_arbiter: directed scenarios plus a
// randomized run compared against a behavioural arbitration/shift model.
module tb_shifter_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        req0, op0, req1, op1;
  logic [31:0] data_operandA0, data_operandA1;
  logic [4:0]  ctrl_shiftamt0, ctrl_shiftamt1;
  logic        gnt0, gnt1, done0, done1;
  logic [31:0] data_result;

  int unsigned errors = 0;
  int unsigned checks = 0;

  shifter_arbiter #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .op0(op0), .data_operandA0(data_operandA0),
    .ctrl_shiftamt0(ctrl_shiftamt0), .gnt0(gnt0),
    .req1(req1), .op1(op1), .data_operandA1(data_operandA1),
    .ctrl_shiftamt1(ctrl_shiftamt1), .gnt1(gnt1),
    .data_result(data_result), .done0(done0), .done1(done1)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] ref_shift(input logic op, input logic [31:0] a,
                                            input logic [4:0] s);
    if (op) return $unsigned($signed(a) >>> s);
    return a << s;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic r0, input logic o0, input logic [31:0] a0,
                       input logic [4:0] s0, input logic r1, input logic o1,
                       input logic [31:0] a1, input logic [4:0] s1);
    req0 = r0; op0 = o0; data_operandA0 = a0; ctrl_shiftamt0 = s0;
    req1 = r1; op1 = o1; data_operandA1 = a1; ctrl_shiftamt1 = s1;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, 32'h1, 5'd1, 1'b1, 1'b0, 32'h1, 5'd1);
    reset = 1'b1;
    step();
    checks++;
    if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_gnt: got %b%b expected 00", gnt0, gnt1);
    end
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (data_result !== 32'h0 || done0 !== 1'b0 || done1 !== 1'b0 ||
          gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle: got res=%h d=%b%b g=%b%b expected all zero",
                 data_result, done0, done1, gnt0, gnt1);
      end
      step();
    end
  endtask

  task automatic test_sll_boundary();
    drive(1'b1, 1'b0, 32'h1, 5'd31, 1'b0, 1'b0, '0, '0);
    #1;
    checks++;
    if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
      errors++;
      $display("FAIL sll_gnt: got %b%b expected 10", gnt0, gnt1);
    end
    step();
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    checks++;
    if (data_result !== 32'h8000_0000 || done0 !== 1'b1 || done1 !== 1'b0) begin
      errors++;
      $display("FAIL sll_31: got res=%h d=%b%b expected 80000000 d=10",
               data_result, done0, done1);
    end
    step();
    checks++;
    if (done0 !== 1'b0 || data_result !== 32'h8000_0000) begin
      errors++;
      $display("FAIL sll_hold: got res=%h d0=%b expected 80000000 d0=0",
               data_result, done0);
    end
  endtask

  task automatic test_sra();
    drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 32'h8000_0000, 5'd4);
    step();
    drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 32'h4000_0000, 5'd30);
    checks++;
    if (data_result !== 32'hF800_0000 || done1 !== 1'b1 || done0 !== 1'b0) begin
      errors++;
      $display("FAIL sra_neg: got res=%h d=%b%b expected f8000000 d=01",
               data_result, done0, done1);
    end
    step();
    drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 32'h9234_5678, 5'd31);
    checks++;
    if (data_result !== 32'h0000_0001 || done1 !== 1'b1) begin
      errors++;
      $display("FAIL sra_pos: got res=%h d1=%b expected 00000001 d1=1",
               data_result, done1);
    end
    step();
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    checks++;
    if (data_result !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL sra_31: got %h expected ffffffff", data_result);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic exp_g;
    do_reset();
    drive(1'b1, 1'b0, 32'h1, 5'd1, 1'b1, 1'b1, 32'hFFFF_FFF0, 5'd4);
    exp_g = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if (gnt0 !== ~exp_g || gnt1 !== exp_g) begin
        errors++;
        $display("FAIL b2b_gnt%0d: got %b%b expected %b%b", i, gnt0, gnt1, ~exp_g, exp_g);
      end
      step();
      checks++;
      if (done0 !== ~exp_g || done1 !== exp_g ||
          data_result !== (exp_g ? 32'hFFFF_FFFF : 32'h2)) begin
        errors++;
        $display("FAIL b2b_done%0d: got res=%h d=%b%b expected res=%h d=%b%b", i,
                 data_result, done0, done1, exp_g ? 32'hFFFF_FFFF : 32'h2, ~exp_g, exp_g);
      end
      exp_g = ~exp_g;
    end
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    step();
  endtask

  task automatic test_shamt_zero();
    drive(1'b1, 1'b0, 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b0, '0, '0);
    step();
    drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 32'hDEAD_BEEF, 5'd0);
    checks++;
    if (data_result !== 32'hDEAD_BEEF || done0 !== 1'b1) begin
      errors++;
      $display("FAIL zero_sll: got %h d0=%b expected deadbeef d0=1", data_result, done0);
    end
    step();
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    checks++;
    if (data_result !== 32'hDEAD_BEEF || done1 !== 1'b1) begin
      errors++;
      $display("FAIL zero_sra: got %h d1=%b expected deadbeef d1=1", data_result, done1);
    end
    step();
  endtask

  task automatic test_reset_midflight();
    do_reset();
    drive(1'b1, 1'b0, 32'h5, 5'd1, 1'b0, 1'b0, '0, '0);
    step();
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (done0 !== 1'b0 || done1 !== 1'b0 || data_result !== 32'h0) begin
      errors++;
      $display("FAIL midreset: got res=%h d=%b%b expected 0 d=00",
               data_result, done0, done1);
    end
    drive(1'b1, 1'b0, 32'h3, 5'd2, 1'b1, 1'b0, 32'h7, 5'd3);
    #1;
    checks++;
    if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
      errors++;
      $display("FAIL midreset_ptr: got %b%b expected 10", gnt0, gnt1);
    end
    step();
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    checks++;
    if (done0 !== 1'b1 || data_result !== 32'hC) begin
      errors++;
      $display("FAIL midreset_after: got res=%h d0=%b expected 0000000c d0=1",
               data_result, done0);
    end
    step();
  endtask

  task automatic test_random();
    int          m_ptr;
    int          winner;
    logic [31:0] exp_res;
    logic [31:0] a0, a1;
    logic        o0, o1, r0, r1;
    logic [4:0]  s0, s1;
    do_reset();
    m_ptr = 0;
    exp_res = '0;
    for (int i = 0; i < 300; i++) begin
      r0 = 1'($urandom_range(0, 1)); r1 = 1'($urandom_range(0, 1));
      o0 = 1'($urandom_range(0, 1)); o1 = 1'($urandom_range(0, 1));
      a0 = $urandom; a1 = $urandom;
      s0 = 5'($urandom_range(0, 31)); s1 = 5'($urandom_range(0, 31));
      drive(r0, o0, a0, s0, r1, o1, a1, s1);
      if (r0 && r1) winner = m_ptr;
      else if (r0)  winner = 0;
      else if (r1)  winner = 1;
      else          winner = -1;
      #1;
      checks++;
      if (gnt0 !== (winner == 0) || gnt1 !== (winner == 1)) begin
        errors++;
        $display("FAIL rand_gnt%0d: got %b%b expected %b%b", i, gnt0, gnt1,
                 winner == 0, winner == 1);
      end
      if (winner == 0) exp_res = ref_shift(o0, a0, s0);
      if (winner == 1) exp_res = ref_shift(o1, a1, s1);
      if (winner >= 0) m_ptr = 1 - winner;
      step();
      checks++;
      if (done0 !== (winner == 0) || done1 !== (winner == 1) || data_result !== exp_res) begin
        errors++;
        $display("FAIL rand_res%0d: got res=%h d=%b%b expected res=%h d=%b%b", i,
                 data_result, done0, done1, exp_res, winner == 0, winner == 1);
      end
    end
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    step();
    test_reset();
    test_sll_boundary();
    test_sra();
    test_back_to_back();
    test_shamt_zero();
    test_reset_midflight();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
